// File: rtl/pea_pkg.sv
// Shared PEA definitions: datapath width and the output-collector state encoding.
package pea_pkg;

   localparam int N_BITS         = 16;
   localparam int OUT_COLL_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } out_coll_state_t;

endpackage

// File: rtl/s_out_fifo.sv
// Registered FIFO with synchronous flush; read data always comes from the
// stored head entry, never from the write port.
module s_out_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 17
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees the slot being written in the same cycle, so push-while-full is legal then.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; entries are only observed once count says valid.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/s_pe_out_collector.sv
// Captures PE results into a FIFO, re-emits them on a valid/ready stream with
// a job-end 'last' tag, and back-pressures the PEA instead of dropping data.
module s_pe_out_collector
   import pea_pkg::*;
#(
   parameter int DEPTH = OUT_COLL_DEPTH,
   parameter int LEN_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  reg_out_len_i,
   input  logic              mage_done_i,
   input  logic [N_BITS-1:0] pe_res_i,
   input  logic              pe_valid_i,
   output logic              pea_ready_o,
   output logic [N_BITS-1:0] stream_data_o,
   output logic              stream_valid_o,
   output logic              stream_last_o,
   input  logic              stream_ready_i,
   output logic              busy_o,
   output logic              done_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   out_coll_state_t  state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] acc_cnt_q, acc_cnt_d;

   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [N_BITS:0]   head;
   logic              accept, pop, is_last;

   assign is_last = (acc_cnt_q == len_q - LEN_W'(1));
   assign accept  = (state_q == RUN) && (len_q != '0) && pe_valid_i && !fifo_full;
   assign pop     = !fifo_empty && stream_ready_i;

   // Depends on registered state and count only, never on stream_ready_i.
   assign pea_ready_o    = (state_q != RUN) || (fifo_count < CW'(DEPTH));
   assign stream_valid_o = !fifo_empty;
   assign stream_data_o  = fifo_empty ? '0 : head[N_BITS-1:0];
   assign stream_last_o  = !fifo_empty && head[N_BITS];
   assign busy_o         = (state_q != IDLE);
   assign done_o         = (state_q == DONE);

   s_out_fifo #(
      .DEPTH (DEPTH),
      .W     (N_BITS + 1)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (accept),
      .pop_i   (pop),
      .flush_i (mage_done_i),
      .wdata_i ({is_last, pe_res_i}),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      acc_cnt_d = acc_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d     = reg_out_len_i;
               acc_cnt_d = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            // A zero-length job spends one cycle here, then completes with no output.
            if (len_q == '0) begin
               state_d = DONE;
            end else if (accept) begin
               acc_cnt_d = acc_cnt_q + LEN_W'(1);
               if (is_last) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head[N_BITS]) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (mage_done_i) begin
         state_d   = IDLE;
         acc_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         len_q     <= '0;
         acc_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         acc_cnt_q <= acc_cnt_d;
      end
   end

endmodule

// File: tb/tb_s_pe_out_collector.sv
// Directed and randomized jobs against a queue-based model of the collector's
// stream, back-pressure and completion behaviour.
module tb_s_pe_out_collector;
   import pea_pkg::*;

   localparam int DEPTH = 4;
   localparam int LEN_W = 16;

   logic              clk_i = 1'b0;
   logic              rst_n_i;
   logic              start_i;
   logic [LEN_W-1:0]  reg_out_len_i;
   logic              mage_done_i;
   logic [N_BITS-1:0] pe_res_i;
   logic              pe_valid_i;
   logic              pea_ready_o;
   logic [N_BITS-1:0] stream_data_o;
   logic              stream_valid_o;
   logic              stream_last_o;
   logic              stream_ready_i;
   logic              busy_o;
   logic              done_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [N_BITS-1:0] fixed_vals [$];

   always #5 clk_i = ~clk_i;

   s_pe_out_collector #(
      .DEPTH (DEPTH),
      .LEN_W (LEN_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .start_i        (start_i),
      .reg_out_len_i  (reg_out_len_i),
      .mage_done_i    (mage_done_i),
      .pe_res_i       (pe_res_i),
      .pe_valid_i     (pe_valid_i),
      .pea_ready_o    (pea_ready_o),
      .stream_data_o  (stream_data_o),
      .stream_valid_o (stream_valid_o),
      .stream_last_o  (stream_last_o),
      .stream_ready_i (stream_ready_i),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic quiet_inputs();
      start_i        = 1'b0;
      mage_done_i    = 1'b0;
      pe_valid_i     = 1'b0;
      stream_ready_i = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  32'(busy_o), 32'd0);
      check({tag, "_done"},  32'(done_o), 32'd0);
      check({tag, "_valid"}, 32'(stream_valid_o), 32'd0);
      check({tag, "_ready"}, 32'(pea_ready_o), 32'd1);
   endtask

   // One job of 'len' results. The model tracks the expected queue contents:
   // every accepted result appears at the tail, the stream shows the head,
   // and 'last' marks result number len. done_o follows the pop of the last one.
   task automatic run_job(input int len, input int vpct, input int rpct,
                          input int rhold, input bit use_fixed);
      logic [N_BITS:0]   q [$];
      logic [N_BITS:0]   e;
      logic [N_BITS-1:0] cur;
      bit have_val, accepting, done_exp, done_next, exp_rdy, acc, pop, finished;
      int n_acc, cyc;
      cur = '0; have_val = 0; n_acc = 0; finished = 0; done_exp = 0;

      start_i = 1'b1; reg_out_len_i = LEN_W'(len);
      pe_valid_i = 1'b0; stream_ready_i = 1'b0; mage_done_i = 1'b0;
      step();
      start_i = 1'b0;
      accepting = 1;

      for (cyc = 0; cyc < 3000; cyc++) begin
         exp_rdy = !(accepting && q.size() == DEPTH);
         check("job_pea_ready", 32'(pea_ready_o), 32'(exp_rdy));
         check("job_valid", 32'(stream_valid_o), 32'(q.size() != 0));
         if (q.size() != 0) begin
            check("job_data", 32'(stream_data_o), 32'(q[0][N_BITS-1:0]));
            check("job_last", 32'(stream_last_o), 32'(q[0][N_BITS]));
         end
         check("job_done", 32'(done_o), 32'(done_exp));
         check("job_busy", 32'(busy_o), 32'd1);
         if (done_exp) begin
            finished = 1;
            break;
         end

         if (!have_val && ($urandom_range(0, 99) < vpct)) begin
            have_val = 1;
            if (use_fixed && fixed_vals.size() != 0) cur = fixed_vals.pop_front();
            else cur = N_BITS'($urandom);
         end
         pe_valid_i     = have_val;
         pe_res_i       = have_val ? cur : N_BITS'($urandom);
         stream_ready_i = (cyc < rhold) ? 1'b0 : ($urandom_range(0, 99) < rpct);
         start_i        = ($urandom_range(0, 9) == 0);
         reg_out_len_i  = LEN_W'($urandom_range(0, 3));

         acc  = accepting && have_val && exp_rdy;
         pop  = (q.size() != 0) && stream_ready_i;
         done_next = 0;
         if (pop) begin
            e = q.pop_front();
            done_next = e[N_BITS];
         end
         if (acc) begin
            q.push_back({(n_acc == len - 1), cur});
            n_acc++;
            if (n_acc == len) accepting = 0;
         end
         if (have_val && exp_rdy) have_val = 0;
         done_exp = done_next;
         step();
      end
      if (!finished) check("job_timeout", 32'd0, 32'd1);
      quiet_inputs();
      step();
      check_idle("job_after");
   endtask

   initial begin
      rst_n_i = 1'b0;
      reg_out_len_i = '0;
      pe_res_i = '0;
      quiet_inputs();
      repeat (2) step();
      check("rst_ready", 32'(pea_ready_o), 32'd1);
      check("rst_valid", 32'(stream_valid_o), 32'd0);
      check("rst_last",  32'(stream_last_o), 32'd0);
      check("rst_data",  32'(stream_data_o), 32'd0);
      check("rst_busy",  32'(busy_o), 32'd0);
      check("rst_done",  32'(done_o), 32'd0);
      rst_n_i = 1'b1;
      step();
      check_idle("post_rst");

      // Basic job: three consecutive results, downstream always ready.
      fixed_vals = '{16'h0011, 16'h0022, 16'h0033};
      run_job(3, 100, 100, 0, 1);

      // Full FIFO: six results with downstream stalled long enough to fill it.
      fixed_vals = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
      run_job(6, 100, 100, 6, 1);

      // Extra valids after the last accept must not be pushed.
      fixed_vals = '{};
      run_job(2, 100, 100, 3, 0);

      // Zero-length job: done two cycles after the start edge, no stream.
      start_i = 1'b1; reg_out_len_i = '0;
      step();
      start_i = 1'b0;
      check("zero_c1_done",  32'(done_o), 32'd0);
      check("zero_c1_busy",  32'(busy_o), 32'd1);
      check("zero_c1_valid", 32'(stream_valid_o), 32'd0);
      step();
      check("zero_c2_done",  32'(done_o), 32'd1);
      check("zero_c2_valid", 32'(stream_valid_o), 32'd0);
      step();
      check_idle("zero_after");

      // Mid-job abort with two entries queued.
      start_i = 1'b1; reg_out_len_i = LEN_W'(5);
      step();
      start_i = 1'b0;
      pe_valid_i = 1'b1; pe_res_i = 16'h00A1;
      step();
      check("abort_q1_data", 32'(stream_data_o), 32'h00A1);
      pe_res_i = 16'h00A2;
      step();
      check("abort_q2_valid", 32'(stream_valid_o), 32'd1);
      pe_valid_i = 1'b0; mage_done_i = 1'b1;
      step();
      mage_done_i = 1'b0;
      check_idle("abort_next");
      check("abort_last", 32'(stream_last_o), 32'd0);
      step();
      check("abort_no_done", 32'(done_o), 32'd0);
      run_job(1, 100, 100, 0, 0);

      // Abort coinciding with the pop of the last entry: abort wins.
      start_i = 1'b1; reg_out_len_i = LEN_W'(1);
      step();
      start_i = 1'b0;
      pe_valid_i = 1'b1; pe_res_i = 16'h005A;
      step();
      pe_valid_i = 1'b0;
      check("lastpop_last", 32'(stream_last_o), 32'd1);
      stream_ready_i = 1'b1; mage_done_i = 1'b1;
      step();
      quiet_inputs();
      check_idle("lastpop_abort");
      step();
      check("lastpop_no_done", 32'(done_o), 32'd0);

      // Randomized jobs.
      for (int j = 0; j < 25; j++) begin
         run_job($urandom_range(1, 12), $urandom_range(30, 100),
                 $urandom_range(20, 100), $urandom_range(0, 6), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
